// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU opcodes, opcode classifiers and Z-stage FSM state type
package cpu_pkg;
    localparam logic [4:0] OP_AND = 5'd0;
    localparam logic [4:0] OP_OR  = 5'd1;
    localparam logic [4:0] OP_ADD = 5'd2;
    localparam logic [4:0] OP_SUB = 5'd3;
    localparam logic [4:0] OP_SHR = 5'd4;
    localparam logic [4:0] OP_SHL = 5'd5;
    localparam logic [4:0] OP_ROR = 5'd6;
    localparam logic [4:0] OP_ROL = 5'd7;
    localparam logic [4:0] OP_NEG = 5'd8;
    localparam logic [4:0] OP_NOT = 5'd9;
    localparam logic [4:0] OP_MUL = 5'd10;
    localparam logic [4:0] OP_DIV = 5'd11;

    typedef enum logic {IDLE, WAIT} state_t;

    function automatic logic is_wide(input logic [4:0] op);
        return op == OP_MUL || op == OP_DIV;
    endfunction

    function automatic logic is_multicycle(input logic [4:0] op);
        return op == OP_MUL || op == OP_DIV;
    endfunction
endpackage

// File: rtl/alu_z_stage_if.sv
// alu_z_stage_if: control, ALU result, multi-cycle handshake and bus signals of the Z stage
interface alu_z_stage_if #(parameter int DATA_W = 32, parameter int OP_W = 5);
    logic              Zin;
    logic [OP_W-1:0]   op_sel;
    logic [DATA_W-1:0] alu_lo;
    logic [DATA_W-1:0] alu_hi;
    logic              mc_done;
    logic              mc_start;
    logic              busy;
    logic [DATA_W-1:0] ZHi;
    logic [DATA_W-1:0] ZLo;
    logic              z_valid;
    logic              zero_flag;
    logic              neg_flag;
    logic              mc_err;
    logic              ZHi_out;
    logic              ZLo_out;
    logic [DATA_W-1:0] bus_out;

    modport master (
        output Zin, op_sel, alu_lo, alu_hi, mc_done, ZHi_out, ZLo_out,
        input  mc_start, busy, ZHi, ZLo, z_valid, zero_flag, neg_flag, mc_err, bus_out
    );
    modport slave (
        input  Zin, op_sel, alu_lo, alu_hi, mc_done, ZHi_out, ZLo_out,
        output mc_start, busy, ZHi, ZLo, z_valid, zero_flag, neg_flag, mc_err, bus_out
    );
endinterface

// File: rtl/reg_32bit.sv
// reg_32bit: register with synchronous active-high clear and load enable
module reg_32bit #(parameter int W = 32) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (clr) q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/alu_z_stage.sv
// alu_z_stage: captures ALU results into ZHi/ZLo, sequences multi-cycle units, drives flags and bus
module alu_z_stage import cpu_pkg::*; #(
    parameter int DATA_W     = 32,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 7
) (
    input logic          clk,
    input logic          clr,
    alu_z_stage_if.slave zif
);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mc_start_q, mc_start_d;
    logic              busy_q, busy_d;
    logic              z_valid_q, z_valid_d;
    logic              zero_q, zero_d;
    logic              neg_q, neg_d;
    logic              mc_err_q, mc_err_d;
    logic              cap, wide;
    logic [DATA_W-1:0] hi_d, lo_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mc_start_d = 1'b0;
        busy_d     = busy_q;
        z_valid_d  = z_valid_q;
        zero_d     = zero_q;
        neg_d      = neg_q;
        mc_err_d   = mc_err_q;
        cap        = 1'b0;
        if (state_q == IDLE) begin
            if (zif.Zin && is_multicycle(zif.op_sel)) begin
                state_d    = WAIT;
                mc_start_d = 1'b1;
                busy_d     = 1'b1;
                z_valid_d  = 1'b0;
                mc_err_d   = 1'b0;
                cnt_d      = '0;
            end else if (zif.Zin) cap = 1'b1;
        end else if (zif.mc_done) begin
            cap     = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
        end else if (cnt_q == CNT_W'(MC_TIMEOUT - 1)) begin
            mc_err_d = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
        end else cnt_d = cnt_q + 1'b1;
        // only multi-cycle (wide) ops ever reach WAIT
        wide = state_q == WAIT || is_wide(zif.op_sel);
        hi_d = wide ? zif.alu_hi : '0;
        lo_d = zif.alu_lo;
        if (cap) begin
            z_valid_d = 1'b1;
            zero_d    = {hi_d, lo_d} == '0;
            neg_d     = wide ? hi_d[DATA_W-1] : lo_d[DATA_W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mc_start_q <= 1'b0;
            busy_q     <= 1'b0;
            z_valid_q  <= 1'b0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            mc_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mc_start_q <= mc_start_d;
            busy_q     <= busy_d;
            z_valid_q  <= z_valid_d;
            zero_q     <= zero_d;
            neg_q      <= neg_d;
            mc_err_q   <= mc_err_d;
        end
    end

    reg_32bit #(.W(DATA_W)) u_zhi (.clk(clk), .clr(clr), .en(cap), .d(hi_d), .q(zif.ZHi));
    reg_32bit #(.W(DATA_W)) u_zlo (.clk(clk), .clr(clr), .en(cap), .d(lo_d), .q(zif.ZLo));

    assign zif.mc_start  = mc_start_q;
    assign zif.busy      = busy_q;
    assign zif.z_valid   = z_valid_q;
    assign zif.zero_flag = zero_q;
    assign zif.neg_flag  = neg_q;
    assign zif.mc_err    = mc_err_q;
    assign zif.bus_out   = zif.ZLo_out ? zif.ZLo : zif.ZHi_out ? zif.ZHi : '0;
endmodule

// File: tb/tb_alu_z_stage.sv
// tb_alu_z_stage: directed self-checking bench for the Z-register stage
module tb_alu_z_stage;
    import cpu_pkg::*;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int checks = 0;
    int errors = 0;

    alu_z_stage_if #(.DATA_W(32), .OP_W(5)) zif ();
    alu_z_stage dut (.clk(clk), .clr(clr), .zif(zif));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        zif.Zin = 0; zif.op_sel = OP_AND; zif.alu_lo = 32'h12345678; zif.alu_hi = 32'h9abcdef0;
        zif.mc_done = 0; zif.ZHi_out = 0; zif.ZLo_out = 1;
        clr = 1; step(); step(); clr = 0;
        checks++; if (zif.ZLo !== 32'h0) begin errors++; $display("FAIL reset_zlo got %h exp %h", zif.ZLo, 32'h0); end
        checks++; if (zif.ZHi !== 32'h0) begin errors++; $display("FAIL reset_zhi got %h exp %h", zif.ZHi, 32'h0); end
        checks++; if ({zif.z_valid, zif.zero_flag, zif.neg_flag, zif.mc_err, zif.mc_start, zif.busy} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp %b", {zif.z_valid, zif.zero_flag, zif.neg_flag, zif.mc_err, zif.mc_start, zif.busy}, 6'b0); end
        checks++; if (zif.bus_out !== 32'h0) begin errors++; $display("FAIL reset_bus got %h exp %h", zif.bus_out, 32'h0); end
        zif.ZLo_out = 0;
    endtask

    task automatic test_single();
        zif.op_sel = OP_NOT; zif.alu_lo = 32'h55555555; zif.alu_hi = 32'hdeadbeef; zif.Zin = 1;
        step(); zif.Zin = 0;
        checks++; if (zif.ZLo !== 32'h55555555) begin errors++; $display("FAIL single_zlo got %h exp %h", zif.ZLo, 32'h55555555); end
        checks++; if (zif.ZHi !== 32'h0) begin errors++; $display("FAIL single_zhi got %h exp %h", zif.ZHi, 32'h0); end
        checks++; if ({zif.z_valid, zif.zero_flag, zif.neg_flag, zif.mc_start, zif.busy} !== 5'b10000) begin
            errors++; $display("FAIL single_ctrl got %b exp %b", {zif.z_valid, zif.zero_flag, zif.neg_flag, zif.mc_start, zif.busy}, 5'b10000); end
    endtask

    task automatic test_mul();
        int starts = 0;
        int busy_cnt = 0;
        zif.op_sel = OP_MUL; zif.alu_hi = 32'h0; zif.alu_lo = 32'h0; zif.Zin = 1;
        step(); zif.Zin = 0;
        checks++; if (zif.z_valid !== 1'b0 || zif.ZLo !== 32'h55555555) begin
            errors++; $display("FAIL mul_wait_hold got valid=%b zlo=%h exp valid=0 zlo=55555555", zif.z_valid, zif.ZLo); end
        for (int k = 0; k < 10; k++) begin
            if (zif.mc_start) starts++;
            if (zif.busy) busy_cnt++;
            zif.mc_done = (k == 5);
            zif.alu_hi = (k == 5) ? 32'h1 : 32'h0;
            zif.alu_lo = (k == 5) ? 32'hfffffffe : 32'h0;
            step();
        end
        checks++; if (starts !== 1) begin errors++; $display("FAIL mul_start_pulses got %0d exp %0d", starts, 1); end
        checks++; if (busy_cnt !== 6) begin errors++; $display("FAIL mul_busy_cycles got %0d exp %0d", busy_cnt, 6); end
        checks++; if (zif.ZHi !== 32'h1 || zif.ZLo !== 32'hfffffffe) begin
            errors++; $display("FAIL mul_result got %h_%h exp %h_%h", zif.ZHi, zif.ZLo, 32'h1, 32'hfffffffe); end
        checks++; if ({zif.z_valid, zif.zero_flag, zif.neg_flag, zif.mc_err} !== 4'b1000) begin
            errors++; $display("FAIL mul_flags got %b exp %b", {zif.z_valid, zif.zero_flag, zif.neg_flag, zif.mc_err}, 4'b1000); end
    endtask

    task automatic test_timeout();
        int n = 0;
        zif.op_sel = OP_DIV; zif.alu_hi = 32'h77777777; zif.alu_lo = 32'h88888888; zif.Zin = 1;
        step(); zif.Zin = 0;
        while (zif.busy && n < 100) begin n++; step(); end
        checks++; if (n !== 64) begin errors++; $display("FAIL timeout_busy_cycles got %0d exp %0d", n, 64); end
        checks++; if ({zif.mc_err, zif.busy, zif.z_valid} !== 3'b100) begin
            errors++; $display("FAIL timeout_ctrl got %b exp %b", {zif.mc_err, zif.busy, zif.z_valid}, 3'b100); end
        checks++; if (zif.ZHi !== 32'h1 || zif.ZLo !== 32'hfffffffe) begin
            errors++; $display("FAIL timeout_hold got %h_%h exp %h_%h", zif.ZHi, zif.ZLo, 32'h1, 32'hfffffffe); end
    endtask

    task automatic test_clr_wait();
        zif.op_sel = OP_MUL; zif.Zin = 1;
        step(); zif.Zin = 0;
        checks++; if ({zif.mc_err, zif.busy, zif.mc_start} !== 3'b011) begin
            errors++; $display("FAIL restart_clears_err got %b exp %b", {zif.mc_err, zif.busy, zif.mc_start}, 3'b011); end
        step();
        zif.op_sel = OP_NOT; zif.alu_lo = 32'h12345678; zif.Zin = 1;
        step(); zif.Zin = 0;
        checks++; if ({zif.busy, zif.z_valid, zif.mc_start} !== 3'b100 || zif.ZLo !== 32'hfffffffe) begin
            errors++; $display("FAIL zin_in_wait got busy/valid/start=%b zlo=%h exp 100 fffffffe", {zif.busy, zif.z_valid, zif.mc_start}, zif.ZLo); end
        clr = 1; step(); clr = 0;
        zif.mc_done = 1; zif.alu_hi = 32'hcafef00d; zif.alu_lo = 32'h8badf00d;
        step(); zif.mc_done = 0;
        checks++; if (zif.ZHi !== 32'h0 || zif.ZLo !== 32'h0) begin
            errors++; $display("FAIL clr_late_done got %h_%h exp %h_%h", zif.ZHi, zif.ZLo, 32'h0, 32'h0); end
        checks++; if ({zif.z_valid, zif.zero_flag, zif.neg_flag, zif.mc_err, zif.mc_start, zif.busy} !== 6'b0) begin
            errors++; $display("FAIL clr_ctrl got %b exp %b", {zif.z_valid, zif.zero_flag, zif.neg_flag, zif.mc_err, zif.mc_start, zif.busy}, 6'b0); end
    endtask

    task automatic test_bus();
        zif.op_sel = OP_MUL; zif.Zin = 1;
        step(); zif.Zin = 0;
        zif.mc_done = 1; zif.alu_hi = 32'h1; zif.alu_lo = 32'haaaaaaaa;
        step(); zif.mc_done = 0;
        checks++; if (zif.ZHi !== 32'h1 || zif.ZLo !== 32'haaaaaaaa || zif.busy !== 1'b0) begin
            errors++; $display("FAIL done_with_start got %h_%h busy=%b exp 00000001_aaaaaaaa busy=0", zif.ZHi, zif.ZLo, zif.busy); end
        zif.ZLo_out = 1; zif.ZHi_out = 1; #1;
        checks++; if (zif.bus_out !== 32'haaaaaaaa) begin errors++; $display("FAIL bus_both got %h exp %h", zif.bus_out, 32'haaaaaaaa); end
        zif.ZLo_out = 0; #1;
        checks++; if (zif.bus_out !== 32'h1) begin errors++; $display("FAIL bus_hi got %h exp %h", zif.bus_out, 32'h1); end
        zif.ZHi_out = 0; #1;
        checks++; if (zif.bus_out !== 32'h0) begin errors++; $display("FAIL bus_none got %h exp %h", zif.bus_out, 32'h0); end
        zif.ZLo_out = 1; #1;
        checks++; if (zif.bus_out !== 32'haaaaaaaa) begin errors++; $display("FAIL bus_lo got %h exp %h", zif.bus_out, 32'haaaaaaaa); end
        zif.ZLo_out = 0;
    endtask

    task automatic test_flags();
        zif.op_sel = OP_AND; zif.alu_lo = 32'h0; zif.alu_hi = 32'hffffffff; zif.Zin = 1;
        step(); zif.Zin = 0;
        checks++; if ({zif.zero_flag, zif.neg_flag} !== 2'b10 || zif.ZHi !== 32'h0) begin
            errors++; $display("FAIL and_zero got z/n=%b zhi=%h exp 10 00000000", {zif.zero_flag, zif.neg_flag}, zif.ZHi); end
        zif.op_sel = OP_NOT; zif.alu_lo = 32'h80000000; zif.Zin = 1;
        step(); zif.Zin = 0;
        checks++; if ({zif.zero_flag, zif.neg_flag} !== 2'b01) begin
            errors++; $display("FAIL not_neg got %b exp %b", {zif.zero_flag, zif.neg_flag}, 2'b01); end
        zif.mc_done = 1; zif.alu_lo = 32'h1234;
        step(); zif.mc_done = 0;
        checks++; if (zif.ZLo !== 32'h80000000) begin errors++; $display("FAIL idle_done_ignored got %h exp %h", zif.ZLo, 32'h80000000); end
        zif.op_sel = OP_DIV; zif.Zin = 1;
        step(); zif.Zin = 0;
        zif.mc_done = 1; zif.alu_hi = 32'h0; zif.alu_lo = 32'h0;
        step(); zif.mc_done = 0;
        checks++; if ({zif.zero_flag, zif.neg_flag} !== 2'b10) begin
            errors++; $display("FAIL wide_zero got %b exp %b", {zif.zero_flag, zif.neg_flag}, 2'b10); end
        zif.op_sel = OP_MUL; zif.Zin = 1;
        step(); zif.Zin = 0;
        zif.mc_done = 1; zif.alu_hi = 32'h80000000; zif.alu_lo = 32'h0;
        step(); zif.mc_done = 0;
        checks++; if ({zif.zero_flag, zif.neg_flag} !== 2'b01) begin
            errors++; $display("FAIL wide_neg got %b exp %b", {zif.zero_flag, zif.neg_flag}, 2'b01); end
        zif.op_sel = OP_MUL; zif.Zin = 1;
        step(); zif.Zin = 0;
        zif.mc_done = 1; zif.alu_hi = 32'h0; zif.alu_lo = 32'h80000000;
        step(); zif.mc_done = 0;
        checks++; if ({zif.zero_flag, zif.neg_flag} !== 2'b00) begin
            errors++; $display("FAIL wide_lo_msb got %b exp %b", {zif.zero_flag, zif.neg_flag}, 2'b00); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mul();
        test_timeout();
        test_clr_wait();
        test_bus();
        test_flags();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
